// File: rtl/line_clear.sv
// line_clear -- post-lock row-clear stage.
// Scans the settled board bottom to top, drops every completely filled row,
// slides the surviving rows down in their original order, then zero-fills the
// vacated rows at the top. It reports the compacted board, the rows removed by
// this operation and a saturating running total.
// Optional feature macro: LINE_CLEAR_SCORE_EN adds a saturating 24-bit
// level-0 score accumulator and the o_score port.
module line_clear #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [ROWS*COLS-1:0]   i_board_in,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [ROWS*COLS-1:0]   o_board_out,
   output logic [4:0]             o_lines_cleared,
   output logic [15:0]            o_total_lines
`ifdef LINE_CLEAR_SCORE_EN
   ,
   output logic [23:0]            o_score
`endif
);

   // Row pointers only need to address ROWS entries.
   localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PW-1:0] LAST_ROW = PW'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                        r_state;
   state_t                        w_state_next;
   logic [PW-1:0]                 r_rptr;
   logic [PW-1:0]                 w_rptr_next;
   logic [PW-1:0]                 r_wptr;
   logic [PW-1:0]                 w_wptr_next;
   logic [4:0]                    r_cnt;
   logic [4:0]                    w_cnt_next;

   // Working board, one packed element per row; element r sits at bits
   // [r*COLS +: COLS] when flattened, matching the bus layout.
   logic [ROWS-1:0][COLS-1:0]     r_work;
   logic [ROWS-1:0][COLS-1:0]     w_work_next;

   logic [COLS-1:0]               w_rd_row;
   logic                          w_row_full;
   logic                          w_enter_done;
   logic                          w_load;

   logic                          r_busy;
   logic                          r_done;
   logic [ROWS*COLS-1:0]          r_board_out;
   logic [4:0]                    r_lines_cleared;
   logic [15:0]                   r_total_lines;
   logic [16:0]                   w_total_sum;
   logic [15:0]                   w_total_next;

   // Row currently being inspected and whether it is completely filled.
   assign w_rd_row   = r_work[r_rptr];
   assign w_row_full = &w_rd_row;
   assign w_load     = (r_state == S_IDLE) && i_start;

   // State register and scan bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_rptr  <= w_rptr_next;
         r_wptr  <= w_wptr_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state and pointer logic: one row per cycle in SCAN, one zeroed row
   // per cycle in FILL. wptr is left equal to cnt-1 after SCAN, so FILL runs
   // exactly cnt cycles.
   always_comb begin
      w_state_next = r_state;
      w_rptr_next  = r_rptr;
      w_wptr_next  = r_wptr;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = S_SCAN;
               w_rptr_next  = LAST_ROW;
               w_wptr_next  = LAST_ROW;
               w_cnt_next   = '0;
            end
         end
         S_SCAN: begin
            w_rptr_next = r_rptr - PW'(1);
            if (w_row_full) begin
               w_cnt_next = r_cnt + 5'd1;
            end else begin
               w_wptr_next = r_wptr - PW'(1);
            end
            if (r_rptr == '0) begin
               w_state_next = (w_cnt_next == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            if (r_wptr == '0) begin
               w_state_next = S_DONE;
            end else begin
               w_wptr_next = r_wptr - PW'(1);
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // DONE is only ever entered from SCAN or FILL, so this is the entry edge.
   assign w_enter_done = (w_state_next == S_DONE);

   // Per-row next value: load on start, copy a surviving row down in SCAN,
   // clear the vacated rows in FILL, otherwise hold.
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         logic w_sel;
         assign w_sel = (r_wptr == PW'(gi));
         assign w_work_next[gi] =
            w_load                                      ? i_board_in[gi*COLS +: COLS] :
            ((r_state == S_SCAN) && !w_row_full && w_sel) ? w_rd_row :
            ((r_state == S_FILL) && w_sel)               ? {COLS{1'b0}} :
                                                           r_work[gi];
      end
   endgenerate

   // Working board register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_work <= '0;
      end else begin
         r_work <= w_work_next;
      end
   end

   // Running line total saturates rather than wrapping.
   assign w_total_sum  = {1'b0, r_total_lines} + {12'd0, w_cnt_next};
   assign w_total_next = w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];

   // Registered result outputs, captured on the edge that enters DONE so they
   // include the final row written in that same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_board_out     <= '0;
         r_lines_cleared <= '0;
         r_total_lines   <= '0;
      end else begin
         r_busy <= (w_state_next != S_IDLE);
         r_done <= w_enter_done;
         if (w_enter_done) begin
            r_board_out     <= w_work_next;
            r_lines_cleared <= w_cnt_next;
            r_total_lines   <= w_total_next;
         end
      end
   end

   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_board_out     = r_board_out;
   assign o_lines_cleared = r_lines_cleared;
   assign o_total_lines   = r_total_lines;

`ifdef LINE_CLEAR_SCORE_EN
   logic [23:0] r_score;
   logic [24:0] w_score_sum;
   logic [23:0] w_score_next;

   // Level-0 points for a clear of cnt rows; four or more is a tetris.
   function automatic logic [10:0] f_points(input logic [4:0] cnt);
      case (cnt)
         5'd0:    f_points = 11'd0;
         5'd1:    f_points = 11'd40;
         5'd2:    f_points = 11'd100;
         5'd3:    f_points = 11'd300;
         default: f_points = 11'd1200;
      endcase
   endfunction

   assign w_score_sum  = {1'b0, r_score} + {14'd0, f_points(w_cnt_next)};
   assign w_score_next = w_score_sum[24] ? 24'hFFFFFF : w_score_sum[23:0];

   // Score accumulator, updated together with the other results.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_score <= '0;
      end else if (w_enter_done) begin
         r_score <= w_score_next;
      end
   end

   assign o_score = r_score;
`endif

endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear -- randomized and directed checks of line_clear against a
// queue-based board-compaction reference model.
module tb_line_clear;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int N    = ROWS * COLS;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic [N-1:0]  board_in = '0;
   logic          busy;
   logic          done;
   logic [N-1:0]  board_out;
   logic [4:0]    lines_cleared;
   logic [15:0]   total_lines;
`ifdef LINE_CLEAR_SCORE_EN
   logic [23:0]   score;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int exp_total = 0;
   int exp_score = 0;

   line_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (start),
      .i_board_in      (board_in),
      .o_busy          (busy),
      .o_done          (done),
      .o_board_out     (board_out),
      .o_lines_cleared (lines_cleared),
      .o_total_lines   (total_lines)
`ifdef LINE_CLEAR_SCORE_EN
      ,
      .o_score         (score)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int points(input int k);
      case (k)
         0:       return 0;
         1:       return 40;
         2:       return 100;
         3:       return 300;
         default: return 1200;
      endcase
   endfunction

   // Reference: keep the non-full rows in top-to-bottom order, stack them at
   // the bottom of an empty board.
   task automatic model(input logic [N-1:0] b, output logic [N-1:0] o, output int k);
      logic [COLS-1:0] q[$];
      logic [COLS-1:0] row;
      logic [COLS-1:0] ones;
      ones = '1;
      for (int r = 0; r < ROWS; r++) begin
         row = b[r*COLS +: COLS];
         if (row != ones) q.push_back(row);
      end
      k = ROWS - q.size();
      o = '0;
      for (int i = 0; i < q.size(); i++) o[(k+i)*COLS +: COLS] = q[i];
   endtask

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i += 32) v[i +: 8] = 8'($urandom);
      for (int i = 0; i < N; i++) v[i] = v[i] ^ 1'($urandom);
      return v;
   endfunction

   function automatic logic [N-1:0] rand_board();
      logic [N-1:0] b;
      for (int r = 0; r < ROWS; r++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: b[r*COLS +: COLS] = '1;
            3:       b[r*COLS +: COLS] = '0;
            default: b[r*COLS +: COLS] = COLS'($urandom);
         endcase
      end
      return b;
   endfunction

   task automatic check_outputs(input string tag, input logic [N-1:0] exp_board, input int k);
      check({tag, " board_out"}, board_out, exp_board);
      check({tag, " lines_cleared"}, N'(lines_cleared), N'(k));
      check({tag, " total_lines"}, N'(total_lines), N'(exp_total));
`ifdef LINE_CLEAR_SCORE_EN
      check({tag, " score"}, N'(score), N'(exp_score));
`endif
   endtask

   // One full operation: start, optional ignored start pulse while busy,
   // latency/result checks, then idle check.
   task automatic run_op(input string tag, input logic [N-1:0] b, input bit poke);
      logic [N-1:0] exp_board;
      int k;
      int n;
      bit got;
      model(b, exp_board, k);
      @(negedge clk);
      start    = 1'b1;
      board_in = b;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      board_in = rand_vec();
      check({tag, " busy rise"}, N'(busy), N'(1));
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         start = poke && (n == 3);
         if (start) board_in = rand_board();
         @(posedge clk);
         n++;
         @(negedge clk);
         start = 1'b0;
         if (done) got = 1'b1;
      end
      if (exp_total + k > 65535) exp_total = 65535; else exp_total = exp_total + k;
      if (exp_score + points(k) > 24'hFFFFFF) exp_score = 24'hFFFFFF;
      else exp_score = exp_score + points(k);
      check({tag, " latency"}, N'(n), N'(ROWS + k));
      check_outputs(tag, exp_board, k);
      @(posedge clk);
      @(negedge clk);
      check({tag, " done one-cycle"}, N'(done), N'(0));
      check({tag, " busy fall"}, N'(busy), N'(0));
      check({tag, " board_out hold"}, board_out, exp_board);
      $display("op %s: k=%0d latency=%0d total=%0d", tag, k, n, exp_total);
   endtask

   initial begin
      logic [N-1:0] b;
      bit saw_done;

      // Reset state
      #12;
      check("reset busy", N'(busy), N'(0));
      check("reset done", N'(done), N'(0));
      check_outputs("reset", '0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single bottom row
      b = '0;
      b[19*COLS +: COLS] = 10'h3FF;
      b[18*COLS +: COLS] = 10'h001;
      run_op("single", b, 1'b0);
      check("single row19 const", N'(board_out[19*COLS +: COLS]), N'(10'h001));

      // Reset mid-run during SCAN cycle 5
      @(negedge clk);
      start    = 1'b1;
      board_in = rand_board();
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_total = 0;
      exp_score = 0;
      check("midrst busy", N'(busy), N'(0));
      check("midrst done", N'(done), N'(0));
      check_outputs("midrst", '0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check("midrst quiet", N'(saw_done), N'(0));
      $display("op midrst: reset during scan");

      // Empty board, then the plan's accumulate sequence
      run_op("empty", '0, 1'b0);
      b = '0;
      b[19*COLS +: COLS] = 10'h3FF;
      b[18*COLS +: COLS] = 10'h001;
      run_op("single2", b, 1'b0);
      b = '0;
      b[19*COLS +: COLS] = 10'h3FF;
      b[18*COLS +: COLS] = 10'h0F0;
      b[17*COLS +: COLS] = 10'h3FF;
      run_op("noncontig", b, 1'b0);
      check("noncontig total const", N'(total_lines), N'(3));

      // Tetris with gaps
      b = '0;
      for (int r = 16; r < 20; r++) b[r*COLS +: COLS] = 10'h3FF;
      b[15*COLS +: COLS] = 10'h155;
      b[10*COLS +: COLS] = 10'h2AA;
      run_op("tetris", b, 1'b0);
      check("tetris row14 const", N'(board_out[14*COLS +: COLS]), N'(10'h2AA));

      // Partial rows only (one bit missing in every row)
      b = '1;
      for (int r = 0; r < ROWS; r++) b[r*COLS + (r % COLS)] = 1'b0;
      run_op("partial", b, 1'b1);

      // Full board with an ignored start pulse during busy
      run_op("full", '1, 1'b1);

      // Random boards
      for (int t = 0; t < 25; t++) begin
         run_op($sformatf("rand%0d", t), rand_board(), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/line_clear.md
# line_clear

Post-lock row-clear stage for the Tetris core. Consumes the settled board after a piece locks, removes every completely filled row, and collapses the rows above it downward. It returns the compacted board plus the number of rows removed, and keeps a running line total. It sits directly downstream of the board-update stage, and its output board becomes that stage's next `board` input.

## Interface

**Parameters**
- `ROWS`, default 20: playfield height.
- `COLS`, default 10: playfield width. The board bus width is `ROWS*COLS`.

**Ports**
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; `board_in` is valid in the same cycle.
- `board_in`  in  `ROWS*COLS`  board to process.
  - Row r occupies bits [r*COLS+COLS-1 : r*COLS].
  - Row 0 is the top row; row `ROWS-1` is the bottom row.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; result outputs are valid in that cycle.
- `board_out`  out  `ROWS*COLS`  compacted board; holds its value until the next `done`.
- `lines_cleared`  out  5  rows removed by the last operation (0..`ROWS`); holds until the next `done`.
- `total_lines`  out  16  running count of cleared rows since reset; saturates at 0xFFFF.
- `score`  out  24  present only with `LINE_CLEAR_SCORE_EN`.

## Operation

**Internal state:** working register `work`, read pointer `rptr`, write pointer `wptr`, clear count `cnt`.

**FSM states:** IDLE, SCAN, FILL, DONE.

- **IDLE**
  - `start`=1: load `work`←`board_in`, `rptr`←`ROWS-1`, `wptr`←`ROWS-1`, `cnt`←0; go to SCAN.
  - `start`=0: remain in IDLE.
- **SCAN** (one row per cycle, bottom to top)
  - If `work[rptr]` is all ones: `cnt`++ and `wptr` is unchanged.
  - Otherwise: `work[wptr]`←`work[rptr]`, then `wptr`--.
  - `rptr`-- every cycle.
  - After row 0 has been processed: if `cnt`=0 go to DONE, else go to FILL.
- **FILL**
  - `work[wptr]`←0 each cycle.
  - When `wptr`=0, go to DONE; otherwise `wptr`--.
  - Exactly `cnt` cycles, zeroing rows 0..`cnt`-1.
- **DONE**
  - Entering DONE loads `board_out`←`work` and `lines_cleared`←`cnt`, and adds `cnt` to `total_lines` (saturating).
  - `done`=1 for this single cycle, then return to IDLE.

**Rules and boundary cases**
- `start` is ignored while `busy`=1, including in DONE.
- Full rows need not be contiguous; any pattern must compact with the relative order of the surviving rows preserved.
- All `ROWS` rows full: `lines_cleared`=`ROWS`, `board_out`=0.
- Empty board: `lines_cleared`=0, `board_out`=`board_in`, and no FILL cycles.
- A row counts as full only when all `COLS` bits are 1. Partial rows are never cleared.
- Reset during any state returns the block to IDLE and discards the in-flight operation.

## Timing

- **Reset values:** `busy`=0, `done`=0, `board_out`=0, `lines_cleared`=0, `total_lines`=0, `score`=0. The FSM resets to IDLE.
- **Latency:** `start` is accepted at edge E0 and `done` is high in the cycle following edge E(`ROWS`+k), where k is the number of cleared rows. With defaults that is 20+k cycles.
- **`busy`:** rises in the cycle after E0 and falls in the cycle after `done`.
- **Back-to-back:** the earliest new `start` is the cycle after `done`.
- **Outputs:** `done` and all result outputs are registered; none is combinational from `start` or `board_in`.

## Configuration

- **`LINE_CLEAR_SCORE_EN` defined:** the `score` port exists.
  - Entering DONE adds the level-0 points for `cnt`: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - The add is a 24-bit accumulate that saturates at 0xFFFFFF.
  - Reset clears `score` to 0.
- **`LINE_CLEAR_SCORE_EN` undefined:** there is no `score` port and no scoring logic. All other behaviour is identical.

## Test plan

- **Reset mid-run:** assert `start`, drop `rst_n` during SCAN cycle 5 → `busy`=0, `done` never pulses, all outputs read 0. A following `start` with an empty board → `done` after 20 cycles.
- **Single bottom row:** row 19=0x3FF, row 18=0x001 → `done` after 21 cycles. `lines_cleared`=1, row 19=0x001, all other rows 0, `total_lines`=1. With the macro, `score`=40.
- **Tetris with gaps:** rows 16..19 all 0x3FF, row 15=0x155, row 10=0x2AA → `done` after 24 cycles. `lines_cleared`=4, row 19=0x155, row 14=0x2AA, `score`=1200.
- **Non-contiguous clears:** rows 19 and 17 full, row 18=0x0F0 → row 19=0x0F0, `lines_cleared`=2, `total_lines` accumulates across runs (1+2=3 if run after the single-row test).
- **Stress and protocol:** full board (200 ones) → `board_out`=0, `lines_cleared`=20, `done` after 40 cycles. `start` pulsed during `busy` is ignored, and exactly one `done` is produced.
